// File: rtl/hs_rr_arbiter_if.sv
// hs_rr_arbiter_if
// Bundles the requester-side and resource-side signals of hs_rr_arbiter.
//   master : arbiter side. It drives ack_o, grant_o, res_req_o, res_data_o,
//            busy_o, timeout_o and dbg_state.
//   slave  : environment side. It drives req_i, data_i and res_ack_i.
// Ports
//   req_i      [N]    four-phase request level, one per requester
//   data_i     [N*W]  requester data, slice k = data_i[k*W +: W]
//   ack_o      [N]    four-phase acknowledge, one per requester
//   grant_o    [N]    one-hot current owner, zero when idle
//   res_req_o         request to the shared resource
//   res_data_o [W]    data latched from the winner at grant
//   res_ack_i         completion from the shared resource
//   busy_o            high whenever the arbiter is not idle
//   timeout_o         one-cycle pulse on watchdog abort
//   dbg_state  [2]    arbiter FSM state (0 IDLE, 1 RES_UP, 2 RES_DN, 3 CLI_ACK)
interface hs_rr_arbiter_if #(
  parameter int N = 4,
  parameter int W = 8
);
  logic [N-1:0]   req_i;
  logic [N*W-1:0] data_i;
  logic [N-1:0]   ack_o;
  logic [N-1:0]   grant_o;
  logic           res_req_o;
  logic [W-1:0]   res_data_o;
  logic           res_ack_i;
  logic           busy_o;
  logic           timeout_o;
  logic [1:0]     dbg_state;

  modport master (
    input  req_i, data_i, res_ack_i,
    output ack_o, grant_o, res_req_o, res_data_o, busy_o, timeout_o, dbg_state
  );

  modport slave (
    output req_i, data_i, res_ack_i,
    input  ack_o, grant_o, res_req_o, res_data_o, busy_o, timeout_o, dbg_state
  );
endinterface

// File: rtl/hs_rr_arbiter.sv
// hs_rr_arbiter
// Clocked round-robin arbiter. It shares one four-phase (return-to-zero)
// handshake resource among N requesters. The arbiter picks a winner, drives
// res_req_o and res_data_o, and waits for res_ack_i to rise and then fall.
// After that it completes the winner's own four-phase handshake. A watchdog
// aborts the transaction if the resource stays too long in either wait state.
//
// Handshake semantics, used on both sides. A request rises and is held. The
// acknowledge rises only once the work is done. The request then falls, and
// the acknowledge falls after it. data_i for a requester must be stable
// while its req_i is high. The arbiter samples data_i once, at grant.
//
// Parameters: N requesters, W data bits per requester, TIMEOUT cycles per
// resource wait state before abort.
// Ports: clk, rst_n (synchronous, active low) and bus (hs_rr_arbiter_if,
// master modport). See the interface file for the signal list.
// Build option: define HS_RR_ARBITER_SYNC_EN to pass res_ack_i through a
// 2-flop synchroniser for truly asynchronous resources. Without it, res_ack_i
// must be synchronous to clk and is used directly.
module hs_rr_arbiter #(
  parameter int N       = 4,
  parameter int W       = 8,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  hs_rr_arbiter_if.master bus
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int SW = IW + 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RES_UP  = 2'd1,
    RES_DN  = 2'd2,
    CLI_ACK = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] win_q, win_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  ack_q, ack_d;
  logic [N-1:0]  grant_q, grant_d;
  logic          res_req_q, res_req_d;
  logic [W-1:0]  res_data_q, res_data_d;
  logic          busy_q;
  logic          timeout_q, timeout_d;

  logic          found;
  logic [IW-1:0] pick;
  logic [IW-1:0] cand;
  logic [SW-1:0] sum;
  logic [W-1:0]  pick_data;
  logic          ack_s;

  // Resource acknowledge as the FSM sees it.
`ifdef HS_RR_ARBITER_SYNC_EN
  logic sync1_q, sync2_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= bus.res_ack_i;
      sync2_q <= sync1_q;
    end
  end

  assign ack_s = sync2_q;
`else
  assign ack_s = bus.res_ack_i;
`endif

  // Round-robin search. It starts at ptr+1 and wraps modulo N. A requester
  // whose ack is still high has already been served and is skipped.
  always_comb begin
    found     = 1'b0;
    pick      = '0;
    cand      = '0;
    sum       = '0;
    pick_data = '0;
    for (int i = 0; i < N; i++) begin
      sum = {1'b0, ptr_q} + SW'(i + 1);
      if (sum >= SW'(N)) sum = sum - SW'(N);
      cand = sum[IW-1:0];
      if (!found && bus.req_i[cand] && !ack_q[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
    for (int k = 0; k < N; k++) begin
      if (pick == IW'(k)) pick_data = bus.data_i[k*W +: W];
    end
  end

  // Next-state and next-output logic. All outputs are registered from these
  // values.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    win_d      = win_q;
    cnt_d      = '0;
    ack_d      = ack_q;
    grant_d    = grant_q;
    res_req_d  = res_req_q;
    res_data_d = res_data_q;
    timeout_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (found) begin
          state_d       = RES_UP;
          win_d         = pick;
          ptr_d         = pick;
          grant_d       = '0;
          grant_d[pick] = 1'b1;
          res_req_d     = 1'b1;
          res_data_d    = pick_data;
        end
      end

      RES_UP: begin
        if (ack_s) begin
          state_d   = RES_DN;
          res_req_d = 1'b0;
        end else if (cnt_q == CW'(TIMEOUT)) begin
          // Abort. ptr already points at this requester, so the others are
          // searched first on the next grant.
          state_d   = IDLE;
          res_req_d = 1'b0;
          grant_d   = '0;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      RES_DN: begin
        if (!ack_s) begin
          state_d      = CLI_ACK;
          ack_d[win_q] = 1'b1;
        end else if (cnt_q == CW'(TIMEOUT)) begin
          state_d   = IDLE;
          res_req_d = 1'b0;
          grant_d   = '0;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      CLI_ACK: begin
        // The requester sets the pace, so this state has no watchdog.
        if (!bus.req_i[win_q]) begin
          state_d = IDLE;
          ack_d   = '0;
          grant_d = '0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= IW'(N - 1);
      win_q      <= '0;
      cnt_q      <= '0;
      ack_q      <= '0;
      grant_q    <= '0;
      res_req_q  <= 1'b0;
      res_data_q <= '0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      win_q      <= win_d;
      cnt_q      <= cnt_d;
      ack_q      <= ack_d;
      grant_q    <= grant_d;
      res_req_q  <= res_req_d;
      res_data_q <= res_data_d;
      busy_q     <= (state_d != IDLE);
      timeout_q  <= timeout_d;
    end
  end

  assign bus.ack_o      = ack_q;
  assign bus.grant_o    = grant_q;
  assign bus.res_req_o  = res_req_q;
  assign bus.res_data_o = res_data_q;
  assign bus.busy_o     = busy_q;
  assign bus.timeout_o  = timeout_q;
  assign bus.dbg_state  = state_q;
endmodule
